// File: rtl/uart_rx_time.sv
// uart_rx_time: 8N1 UART receiver (LSB first, idle high) with a "MM:SS\r" time-string
// parser feeding the digital clock.
// Optional build macro RX_MAJORITY_EN: each start/data/stop decision uses a 2-of-3
// majority of the synchronised line around the nominal sample cycle. Ports and timing
// are identical with or without it.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line idle, waiting for rxd_s low
// S_START | counting to the middle of the start bit, confirming it is low
// S_DATA  | sampling 8 data bits at mid-bit, LSB first
// S_STOP  | sampling the stop bit; high -> byte out, low -> frame error
// S_BREAK | line held low after a frame error, waiting for it to go high

module uart_rx_time #(
   parameter int CLKS_PER_BIT = 1085,
   parameter int MAX_VAL      = 59
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_strobe,
   output logic       frame_err,
   output logic [5:0] mm,
   output logic [5:0] ss,
   output logic       time_valid,
   output logic       parse_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [6:0]    VAL_MAX  = 7'(MAX_VAL);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_cnt_q;
   logic [7:0]    shift_q;
   logic [7:0]    rx_data_q;
   logic          rx_strobe_q;
   logic          frame_err_q;

   logic          rxd_m_q;
   logic          rxd_s_q;
   logic          sample_d;

   logic [2:0]    idx_q;
   logic [3:0]    tens_q;
   logic [5:0]    mm_tmp_q;
   logic [5:0]    ss_tmp_q;
   logic [5:0]    mm_q;
   logic [5:0]    ss_q;
   logic          time_valid_q;
   logic          parse_err_q;

   logic          is_digit_d;
   logic [6:0]    val_d;
   logic          val_ok_d;

`ifdef RX_MAJORITY_EN
   logic          rxd_p_q;

   // Previous synchronised sample, the "one before" vote of the majority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rxd_p_q <= 1'b1;
      else        rxd_p_q <= rxd_s_q;
   end

   // rxd_m_q already holds what rxd_s_q will be next cycle, so the vote covers
   // cycles n-1, n, n+1 while the decision still happens at cycle n.
   always_comb begin
      sample_d = (rxd_p_q & rxd_s_q) | (rxd_s_q & rxd_m_q) | (rxd_p_q & rxd_m_q);
   end
`else
   // Single sample at the nominal cycle.
   always_comb begin
      sample_d = rxd_s_q;
   end
`endif

   // Two-flop synchroniser for the asynchronous serial line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_m_q <= 1'b1;
         rxd_s_q <= 1'b1;
      end else begin
         rxd_m_q <= rxd;
         rxd_s_q <= rxd_m_q;
      end
   end

   // Receive FSM: bit timing, byte assembly and registered strobe/error pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_strobe_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_strobe_q <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!rxd_s_q) begin
                  cnt_q   <= '0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_q <= '0;
                  if (sample_d) begin
                     state_q <= S_IDLE;
                  end else begin
                     bit_cnt_q <= '0;
                     state_q   <= S_DATA;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  shift_q <= {sample_d, shift_q[7:1]};
                  if (bit_cnt_q == 3'd7) state_q <= S_STOP;
                  else                   bit_cnt_q <= bit_cnt_q + 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_STOP: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q <= '0;
                  if (sample_d) begin
                     rx_data_q   <= shift_q;
                     rx_strobe_q <= 1'b1;
                     state_q     <= S_IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= S_BREAK;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_BREAK: begin
               if (rxd_s_q) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Digit classification and two-digit value of the byte just received.
   always_comb begin
      is_digit_d = (rx_data_q >= 8'h30) && (rx_data_q <= 8'h39);
      val_d      = {3'b000, tens_q} * 7'd10 + {3'b000, rx_data_q[3:0]};
      val_ok_d   = is_digit_d && (val_d <= VAL_MAX);
   end

   // Parser: walks "MM:SS\r" one byte per strobe; any bad byte restarts at idx 0,
   // which also makes a stray CR resynchronise the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q        <= '0;
         tens_q       <= '0;
         mm_tmp_q     <= '0;
         ss_tmp_q     <= '0;
         mm_q         <= '0;
         ss_q         <= '0;
         time_valid_q <= 1'b0;
         parse_err_q  <= 1'b0;
      end else begin
         time_valid_q <= 1'b0;
         parse_err_q  <= 1'b0;
         if (frame_err_q) begin
            idx_q <= '0;
         end else if (rx_strobe_q) begin
            case (idx_q)
               3'd0, 3'd3: begin
                  if (is_digit_d) begin
                     tens_q <= rx_data_q[3:0];
                     idx_q  <= idx_q + 1'b1;
                  end else begin
                     parse_err_q <= 1'b1;
                     idx_q       <= '0;
                  end
               end
               3'd1: begin
                  if (val_ok_d) begin
                     mm_tmp_q <= val_d[5:0];
                     idx_q    <= 3'd2;
                  end else begin
                     parse_err_q <= 1'b1;
                     idx_q       <= '0;
                  end
               end
               3'd2: begin
                  if (rx_data_q == 8'h3A) begin
                     idx_q <= 3'd3;
                  end else begin
                     parse_err_q <= 1'b1;
                     idx_q       <= '0;
                  end
               end
               3'd4: begin
                  if (val_ok_d) begin
                     ss_tmp_q <= val_d[5:0];
                     idx_q    <= 3'd5;
                  end else begin
                     parse_err_q <= 1'b1;
                     idx_q       <= '0;
                  end
               end
               3'd5: begin
                  if (rx_data_q == 8'h0D) begin
                     mm_q         <= mm_tmp_q;
                     ss_q         <= ss_tmp_q;
                     time_valid_q <= 1'b1;
                  end else begin
                     parse_err_q <= 1'b1;
                  end
                  idx_q <= '0;
               end
               default: idx_q <= '0;
            endcase
         end
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_strobe  = rx_strobe_q;
   assign frame_err  = frame_err_q;
   assign mm         = mm_q;
   assign ss         = ss_q;
   assign time_valid = time_valid_q;
   assign parse_err  = parse_err_q;

endmodule

// File: tb/tb_uart_rx_time.sv
// Directed bench for uart_rx_time, run at a short bit time to keep frames small.
module tb_uart_rx_time;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rxd = 1'b1;
   logic [7:0] rx_data;
   logic       rx_strobe;
   logic       frame_err;
   logic [5:0] mm;
   logic [5:0] ss;
   logic       time_valid;
   logic       parse_err;

   uart_rx_time #(.CLKS_PER_BIT(CPB), .MAX_VAL(59)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rxd        (rxd),
      .rx_data    (rx_data),
      .rx_strobe  (rx_strobe),
      .frame_err  (frame_err),
      .mm         (mm),
      .ss         (ss),
      .time_valid (time_valid),
      .parse_err  (parse_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Pulse monitor, sampled on the falling edge.
   logic [7:0] rx_log[$];
   int n_rx = 0, n_fe = 0, n_tv = 0, n_pe = 0, n_both = 0;
   int cyc = 0, last_stb_cyc = 0, tv_cyc = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rx_strobe) begin
         rx_log.push_back(rx_data);
         n_rx++;
         last_stb_cyc = cyc;
      end
      if (frame_err) n_fe++;
      if (time_valid) begin
         n_tv++;
         tv_cyc = cyc;
      end
      if (parse_err) n_pe++;
      if (rx_strobe && frame_err) n_both++;
   end

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (CPB) @(negedge clk);
      rxd = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_time(input logic [7:0] m1, input logic [7:0] m0,
                            input logic [7:0] s1, input logic [7:0] s0, input int gap);
      send_byte(m1, 1'b1, gap);
      send_byte(m0, 1'b1, gap);
      send_byte(8'h3A, 1'b1, gap);
      send_byte(s1, 1'b1, gap);
      send_byte(s0, 1'b1, gap);
      send_byte(8'h0D, 1'b1, gap);
      idle(3 * CPB);
   endtask

   logic [7:0] exp1[6];
   int b_rx, b_fe, b_tv, b_pe;
   logic [31:0] got;

   task automatic snap();
      b_rx = n_rx;
      b_fe = n_fe;
      b_tv = n_tv;
      b_pe = n_pe;
   endtask

   initial begin
      exp1 = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h0D};

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_rx_data", rx_data, 0);
      check_eq("rst_mm", mm, 0);
      check_eq("rst_ss", ss, 0);
      check_eq("rst_pulses", {rx_strobe, frame_err, time_valid, parse_err}, 0);
      rst_n = 1'b1;
      idle(2 * CPB);

      // "12:34\r" with an idle gap between bytes
      snap();
      send_time(8'h31, 8'h32, 8'h33, 8'h34, CPB);
      check_eq("t1_strobes", n_rx - b_rx, 6);
      for (int i = 0; i < 6; i++) begin
         got = (b_rx + i < rx_log.size()) ? 32'(rx_log[b_rx + i]) : 32'hFFFF_FFFF;
         check_eq($sformatf("t1_byte%0d", i), got, 32'(exp1[i]));
      end
      check_eq("t1_mm", mm, 12);
      check_eq("t1_ss", ss, 34);
      check_eq("t1_time_valid", n_tv - b_tv, 1);
      check_eq("t1_tv_after_strobe", tv_cyc - last_stb_cyc, 1);
      check_eq("t1_errs", (n_fe - b_fe) + (n_pe - b_pe), 0);

      // "05:09\r" back-to-back
      snap();
      send_time(8'h30, 8'h35, 8'h30, 8'h39, 0);
      check_eq("t2_strobes", n_rx - b_rx, 6);
      check_eq("t2_mm", mm, 5);
      check_eq("t2_ss", ss, 9);
      check_eq("t2_time_valid", n_tv - b_tv, 1);
      check_eq("t2_frame_err", n_fe - b_fe, 0);

      // Out-of-range and non-digit frames are rejected, mm/ss hold
      snap();
      send_time(8'h36, 8'h31, 8'h30, 8'h30, 2);
      check_eq("t5_61_parse_err", (n_pe - b_pe) != 0, 1);
      check_eq("t5_61_no_tv", n_tv - b_tv, 0);
      snap();
      send_time(8'h31, 8'h78, 8'h30, 8'h30, 2);
      check_eq("t5_1x_parse_err", (n_pe - b_pe) != 0, 1);
      check_eq("t5_1x_no_tv", n_tv - b_tv, 0);
      snap();
      send_time(8'h30, 8'h30, 8'h36, 8'h30, 2);
      check_eq("t5_ss60_parse_err", (n_pe - b_pe) != 0, 1);
      check_eq("t5_ss60_no_tv", n_tv - b_tv, 0);
      check_eq("t5_mm_hold", mm, 5);
      check_eq("t5_ss_hold", ss, 9);
      snap();
      send_time(8'h35, 8'h39, 8'h35, 8'h39, 2);
      check_eq("t5_59_mm", mm, 59);
      check_eq("t5_59_ss", ss, 59);
      check_eq("t5_59_tv", n_tv - b_tv, 1);
      check_eq("t5_59_no_pe", n_pe - b_pe, 0);

      // Short low glitch on an idle line
      snap();
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      idle(4 * CPB);
      check_eq("t3_glitch_strobe", n_rx - b_rx, 0);
      check_eq("t3_glitch_ferr", n_fe - b_fe, 0);
      send_time(8'h30, 8'h30, 8'h30, 8'h30, 2);
      check_eq("t3_mm", mm, 0);
      check_eq("t3_ss", ss, 0);
      check_eq("t3_tv", n_tv - b_tv, 1);

      // 0x41 with a low stop bit, then a good frame
      send_time(8'h31, 8'h31, 8'h32, 8'h32, 2);
      snap();
      send_byte(8'h41, 1'b0, 3 * CPB);
      check_eq("t4_frame_err", n_fe - b_fe, 1);
      check_eq("t4_no_strobe", n_rx - b_rx, 0);
      check_eq("t4_no_pe", n_pe - b_pe, 0);
      send_time(8'h30, 8'h30, 8'h30, 8'h30, 2);
      check_eq("t4_mm", mm, 0);
      check_eq("t4_ss", ss, 0);
      check_eq("t4_tv", n_tv - b_tv, 1);

      // Reset asserted during data bit 3 of a byte
      send_time(8'h35, 8'h39, 8'h35, 8'h39, 2);
      snap();
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rxd = i[0];
         repeat (CPB) @(negedge clk);
      end
      rxd = 1'b1;
      repeat (CPB / 2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t6_async_mm", mm, 0);
      check_eq("t6_async_ss", ss, 0);
      check_eq("t6_async_rx_data", rx_data, 0);
      idle(3);
      rst_n = 1'b1;
      idle(2 * CPB);
      check_eq("t6_no_partial_byte", n_rx - b_rx, 0);
      send_time(8'h32, 8'h33, 8'h34, 8'h35, 2);
      check_eq("t6_mm", mm, 23);
      check_eq("t6_ss", ss, 45);
      check_eq("t6_tv", n_tv - b_tv, 1);

      check_eq("strobe_with_frame_err", n_both, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
